alu_exec_unit: RTL
==================

# alu_exec_unit

Handshaked, multi-cycle execution unit that consumes the 3-bit `ALU_control` code produced by the ALU control decoder and executes it on two WIDTH-bit operands. Sits between decode/operand-fetch and writeback in the multi-cycle core variant. Logic ops, add/sub and SLT finish in one cycle. Shifts run serially, one bit per cycle, unless the barrel shifter is compiled in. Results are held until the consumer accepts them.

## Interface
- `WIDTH`, 32: operand and result width.
- `SHAMT_W`, 5: shift-amount width; must equal $clog2(WIDTH).
- `clk`  input  1  clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  operation request valid.
- `in_ready`  output  1  unit can accept a request this cycle.
- `ALU_control`  input  3  op code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL.
- `src_a`  input  WIDTH  operand A; the value shifted for SLL/SRL.
- `src_b`  input  WIDTH  operand B; `src_b[SHAMT_W-1:0]` is the shift amount.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  consumer accepts the result.
- `result`  output  WIDTH  registered result.
- `zero`  output  1  registered; 1 when `result == 0`.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- A request is accepted when `in_valid && in_ready`. `ALU_control`, `src_a` and `src_b` are captured on that edge. Inputs are don't-care at all other times.
- `in_ready = !rst && (state==IDLE || (state==DONE && out_ready))`. This allows back-to-back operation when the consumer drains the result.
- Accepting a non-shift op, or a shift with shift amount 0: the result is computed and registered, and the FSM moves to DONE.
- Accepting a shift with shift amount N>0: the working register is loaded with `src_a`, a counter is loaded with N, and the FSM moves to SHIFT.
- SHIFT: each cycle the working register shifts 1 bit (SLL left, SRL right, zero-fill) and the counter decrements. When the counter is 1, the final shifted value is written to `result` and the FSM moves to DONE.
- DONE: `out_valid=1`. `result` and `zero` are held stable until `out_ready`.
  - On `out_ready` without a new accept, go to IDLE.
  - On `out_ready` with a simultaneous accept, go directly to the new op's next state.
- Arithmetic rules:
  - ADD/SUB are modulo 2^WIDTH. Carry and overflow are discarded.
  - SLT is a signed two's-complement compare, giving result {WIDTH-1 zeros, a<b}.
  - AND/OR/XOR are bitwise.
- Reset:
  - `out_valid=0`, `result=0`, `zero=0`, FSM goes to IDLE, counter cleared.
  - `in_ready=0` while `rst` is high.
  - Reset mid-SHIFT or in DONE abandons the operation with no output.

## Timing
- Latency is counted from the accept edge to the first cycle with `out_valid=1`:
  - non-shift ops and shifts with shift amount 0: 1 cycle;
  - shift by N (serial): N+1 cycles.
- Throughput with `out_ready` held high: one non-shift op per cycle; one serial shift per N+1 cycles.
- `in_ready` stays 0 throughout SHIFT.
- With `out_ready` low in DONE, `in_ready` stays 0 and the outputs stay frozen.
- First accept is possible in the first cycle after `rst` deasserts.

## Configuration
- `ALU_BARREL_SHIFT_EN`
  - Defined: SLL/SRL use a combinational barrel shifter. All ops have 1-cycle latency, and the SHIFT state and counter are not built.
  - Undefined: serial shifter as described above; shift latency is N+1 cycles.

## Test plan
- Reset: hold `rst` high for 3 cycles mid-SHIFT → `out_valid=0`, `result=0`, `zero=0` and `in_ready=0` during reset; `in_ready=1` on the first cycle after.
- Arithmetic, `out_ready` held high, back-to-back:
  - ADD 0xFFFFFFFF+1 → `result=0`, `zero=1` one cycle after accept.
  - SUB 5-7 → 0xFFFFFFFE, `zero=0`.
- SLT: -3 (0xFFFFFFFD) vs 2 → 1; 2 vs -3 → 0. Logic ops: AND 0xF0F0, 0xFF00 → 0xF000; OR → 0xFFF0; XOR → 0x0FF0.
- Serial shifts:
  - SLL 0x1 by 31 → 0x80000000 with `out_valid` exactly 32 cycles after accept; `in_ready=0` meanwhile.
  - SRL 0x80000000 by 4 → 0x08000000 after 5 cycles.
  - Shift by 0 → `src_a` after 1 cycle.
- Backpressure: hold `out_ready` low 4 cycles in DONE → `result`, `zero` and `out_valid` stable and `in_ready=0`. Raising `out_ready` together with `in_valid` → next op accepted the same cycle.
- With `ALU_BARREL_SHIFT_EN` defined: SLL 0x3 by 30 → 0xC0000000 one cycle after accept; all ops sustain one per cycle.

Source files
------------

// File: rtl/alu_exec_unit.sv
// ============================================================================
//  Module   : alu_exec_unit
//  Purpose  : Handshaked execution unit for the multi-cycle core. Executes the
//             3-bit ALU_control code on two WIDTH-bit operands. Logic ops,
//             add/sub and SLT complete in one cycle; shifts run serially one
//             bit per cycle unless the barrel shifter is compiled in. The
//             result is held until the consumer accepts it.
//  Ports    : clk, rst         - clock, synchronous active-high reset
//             in_valid/in_ready - request handshake (captures op + operands)
//             ALU_control      - 000 ADD 001 SUB 010 AND 011 OR 100 XOR
//                                101 SLT 110 SLL 111 SRL
//             src_a, src_b     - operands; src_b[SHAMT_W-1:0] = shift amount
//             out_valid/out_ready - result handshake
//             result, zero     - registered result and result==0 flag
//  Config   : ALU_BARREL_SHIFT_EN - when defined, shifts use a combinational
//             barrel shifter (1-cycle latency, no SHIFT state or counter).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALU_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam logic [2:0] C_OP_ADD = 3'b000;
    localparam logic [2:0] C_OP_SUB = 3'b001;
    localparam logic [2:0] C_OP_AND = 3'b010;
    localparam logic [2:0] C_OP_OR  = 3'b011;
    localparam logic [2:0] C_OP_XOR = 3'b100;
    localparam logic [2:0] C_OP_SLT = 3'b101;
    localparam logic [2:0] C_OP_SLL = 3'b110;
    localparam logic [2:0] C_OP_SRL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;

    logic               w_accept;
    logic               w_slt;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_op_value;

`ifndef ALU_BARREL_SHIFT_EN
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               left_q, left_d;
    logic               w_is_shift;
    logic [WIDTH-1:0]   w_work_step;

    // SLL and SRL are the only codes with both upper bits set.
    assign w_is_shift  = (ALU_control[2:1] == 2'b11);
    assign w_work_step = left_q ? (work_q << 1) : (work_q >> 1);
`endif

    assign in_ready  = !rst && ((state_q == ST_IDLE) ||
                                ((state_q == ST_DONE) && out_ready));
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;

    assign w_shamt = src_b[SHAMT_W-1:0];
    assign w_slt   = ($signed(src_a) < $signed(src_b));

    // Single-cycle result. In the serial build the shift entries only matter
    // for a shift amount of zero, where the result is src_a unchanged.
    always_comb begin
        w_op_value = '0;
        case (ALU_control)
            C_OP_ADD: w_op_value = src_a + src_b;
            C_OP_SUB: w_op_value = src_a - src_b;
            C_OP_AND: w_op_value = src_a & src_b;
            C_OP_OR:  w_op_value = src_a | src_b;
            C_OP_XOR: w_op_value = src_a ^ src_b;
            C_OP_SLT: w_op_value = {{(WIDTH-1){1'b0}}, w_slt};
`ifdef ALU_BARREL_SHIFT_EN
            C_OP_SLL: w_op_value = src_a << w_shamt;
            C_OP_SRL: w_op_value = src_a >> w_shamt;
`else
            C_OP_SLL: w_op_value = src_a;
            C_OP_SRL: w_op_value = src_a;
`endif
            default:  w_op_value = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifndef ALU_BARREL_SHIFT_EN
        work_d   = work_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
`endif
        case (state_q)
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
`ifndef ALU_BARREL_SHIFT_EN
            ST_SHIFT: begin
                work_d = w_work_step;
                cnt_d  = cnt_q - SHAMT_W'(1);
                // Last step: publish the fully shifted value directly.
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d = w_work_step;
                    zero_d   = (w_work_step == '0);
                    state_d  = ST_DONE;
                end
            end
`endif
            default: ;
        endcase

        // An accept overrides the DONE->IDLE drain so back-to-back ops
        // proceed straight to their next state.
        if (w_accept) begin
`ifndef ALU_BARREL_SHIFT_EN
            if (w_is_shift && (w_shamt != '0)) begin
                work_d  = src_a;
                cnt_d   = w_shamt;
                left_d  = ~ALU_control[0];
                state_d = ST_SHIFT;
            end else begin
                result_d = w_op_value;
                zero_d   = (w_op_value == '0);
                state_d  = ST_DONE;
            end
`else
            result_d = w_op_value;
            zero_d   = (w_op_value == '0);
            state_d  = ST_DONE;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            work_q   <= '0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
`ifndef ALU_BARREL_SHIFT_EN
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
`endif
        end
    end

endmodule

`default_nettype wire
